// File: rtl/cpu_if_arbiter.sv
// cpu_if_arbiter: round-robin arbiter sharing one CPU interface target among N_REQ requesters.
// Each access runs IDLE -> ISSUE -> WAIT -> DONE: the one-cycle strobe comes out in ISSUE,
// and the done pulse comes out in DONE.
// Optional feature: define CPU_IF_ARB_TIMEOUT_EN to build a watchdog. It aborts a WAIT that
// lasts TIMEOUT_CYC cycles and flags the abort on req_err.
module cpu_if_arbiter #(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req_read,
   input  logic [N_REQ-1:0]          req_write,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*DATA_W-1:0]   req_wdata,
   output logic [N_REQ-1:0]          req_done,
   output logic [DATA_W-1:0]         req_rdata,
   output logic                      req_err,
   output logic                      cpu_read,
   output logic                      cpu_write,
   output logic [ADDR_W-1:0]         cpu_addr,
   output logic [DATA_W-1:0]         cpu_wdata,
   input  logic [DATA_W-1:0]         cpu_rdata,
   input  logic                      cpu_access_complete,
   input  logic                      cpu_access_ready
);

   localparam int unsigned IDX_W = $clog2(N_REQ);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   grant_q, grant_d;
   logic               op_write_q, op_write_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic [N_REQ-1:0]   done_q, done_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic               err_q, err_d;
   logic               rd_q, rd_d;
   logic               wr_q, wr_d;

   logic [N_REQ-1:0]   req_act;
   logic               win_found;
   logic [IDX_W-1:0]   win_idx;
   logic [IDX_W-1:0]   cand;
   logic               timeout;

   assign req_act = req_read | req_write;

`ifdef CPU_IF_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Watchdog counter: cleared in ISSUE, counts WAIT cycles.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == StIssue) begin
         cnt_d = '0;
      end else if (state_q == StWait) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Watchdog counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The last allowed WAIT cycle is the one in which the counter reaches TIMEOUT_CYC.
   assign timeout = (state_q == StWait) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
   logic unused_timeout_cyc;

   assign unused_timeout_cyc = ^TIMEOUT_CYC;
   assign timeout            = 1'b0;
`endif

   // Round-robin search: first active requester at or above rr_ptr, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand = IDX_W'((32'(rr_ptr_q) + i) % N_REQ);
         if (!win_found && req_act[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Next-state logic and registered-output next values.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_d    = grant_q;
      op_write_d = op_write_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      done_d     = '0;
      rdata_d    = rdata_q;
      err_d      = err_q;
      rd_d       = 1'b0;
      wr_d       = 1'b0;
      case (state_q)
         StIdle: begin
            if (cpu_access_ready && win_found) begin
               grant_d    = win_idx;
               // A write request wins over a simultaneous read request.
               op_write_d = req_write[win_idx];
               addr_d     = req_addr[32'(win_idx) * ADDR_W +: ADDR_W];
               wdata_d    = req_wdata[32'(win_idx) * DATA_W +: DATA_W];
               wr_d       = req_write[win_idx];
               rd_d       = ~req_write[win_idx];
               state_d    = StIssue;
            end
         end
         StIssue: begin
            state_d = StWait;
         end
         StWait: begin
            if (cpu_access_complete) begin
               rdata_d          = op_write_q ? '0 : cpu_rdata;
               err_d            = 1'b0;
               done_d[grant_q]  = 1'b1;
               state_d          = StDone;
            end else if (timeout) begin
               rdata_d          = '0;
               err_d            = 1'b1;
               done_d[grant_q]  = 1'b1;
               state_d          = StDone;
            end
         end
         StDone: begin
            rr_ptr_d = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
            state_d  = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         op_write_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         done_q     <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         op_write_q <= op_write_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         done_q     <= done_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
      end
   end

   assign req_done  = done_q;
   assign req_rdata = rdata_q;
   assign req_err   = err_q;
   assign cpu_read  = rd_q;
   assign cpu_write = wr_q;
   assign cpu_addr  = addr_q;
   assign cpu_wdata = wdata_q;

endmodule
